// File: rtl/shift_sequencer.sv
// shift_sequencer: a multi-cycle left shifter (dout = din << shamt) built on the
// fixed shift-by-2 left_shifter. When shamt is odd, a final 1-bit step finishes
// the shift. busy and done are decoded from registered state only, so no input
// has a combinational path to an output.
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the abort (flush) port.

// Fixed shift-by-2 block; en=0 passes the operand through unchanged.
module left_shifter (
    input  logic        en,
    input  logic [31:0] number,
    output logic [31:0] shifted
);
    assign shifted = en ? {number[29:0], 2'b00} : number;
endmodule

module shift_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  shamt,
    input  logic [31:0] din,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] dout
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  rem_q, rem_d;
    logic [31:0] acc_shl2;

    // Shift-by-2 step, always enabled; only its acc<<2 result is used.
    left_shifter u_left_shifter (
        .en      (1'b1),
        .number  (acc_q),
        .shifted (acc_shl2)
    );

    // Next state and datapath: load on accept, then consume rem two bits at a time.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = din;
                    rem_d   = shamt;
                    state_d = (shamt == 5'd0) ? DONE : SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (rem_q >= 5'd2) begin
                    acc_d = acc_shl2;
                    rem_d = rem_q - 5'd2;
                end else begin
                    // An odd remainder ends with a single-bit step.
                    acc_d = {acc_q[30:0], 1'b0};
                    rem_d = 5'd0;
                end
                state_d = (rem_d == 5'd0) ? DONE : SHIFT;
`ifdef SHIFT_SEQ_ABORT_EN
                // A flush drops the operation and clears the result, so done never pulses for it.
                if (abort) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    rem_d   = '0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over start and abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign dout = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer. A scoreboard queue holds each accepted
// operation's expected result and the cycle in which done must pulse. A
// negedge monitor pops the queue and compares whenever done is seen.
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  shamt;
    logic [31:0] din;
`ifdef SHIFT_SEQ_ABORT_EN
    logic        abort;
`endif
    logic        busy;
    logic        done;
    logic [31:0] dout;

    typedef struct {
        logic [31:0] dout;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   b;

    shift_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .shamt (shamt),
        .din   (din),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: present start for one edge and optionally record the expected result.
    task automatic issue(input logic [31:0] d, input logic [4:0] s, input bit expect_done);
        int          sv;
        logic [31:0] e;
        exp_t        item;
        sv    = int'(s);
        e     = d << s;
        start = 1'b1;
        din   = d;
        shamt = s;
        if (expect_done) begin
            item.dout = e;
            item.cyc  = cyc + 1 + (sv + 1) / 2;
            sb.push_back(item);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting the busy cycles seen on the way.
    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) return;
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        check("done_timeout", {31'b0, done}, 32'd1);
    endtask

    // Scoreboard monitor: each done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", dout, e.dout);
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("busy_with_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        din   = 32'hDEADBEEF;
        shamt = 5'd3;
`ifdef SHIFT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        // Reset held for two edges with start asserted.
        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_dout", dout, 32'h0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Even and zero shift amounts.
        issue(32'h00000003, 5'd2, 1'b1);
        wait_done(b);
        check("busy_cycles_s2", 32'(b), 32'd1);
        @(negedge clk);
        issue(32'h55555555, 5'd0, 1'b1);
        wait_done(b);
        @(negedge clk);

        // Maximum shift: only din[0] survives.
        issue(32'h55555555, 5'd31, 1'b1);
        check("accept_load", dout, 32'h55555555);
        wait_done(b);
        check("busy_cycles_s31", 32'(b), 32'd16);
        @(negedge clk);

        // Odd shift with a start pulse mid-shift that must be ignored.
        issue(32'h00000001, 5'd5, 1'b1);
        start = 1'b1;
        din   = 32'hFFFFFFFF;
        shamt = 5'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(b);
        @(negedge clk);

        // Back-to-back: a new start is presented during the DONE cycle.
        issue(32'hF0000001, 5'd3, 1'b1);
        wait_done(b);
        issue(32'h00000001, 5'd4, 1'b1);
        wait_done(b);
        check("busy_cycles_b2b", 32'(b), 32'd2);
        @(negedge clk);
        check("idle_after_done", {30'b0, busy, done}, 32'd0);

        // Reset in the middle of a shamt=20 operation.
        issue(32'hFFFFFFFF, 5'd20, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_dout", dout, 32'h0);
        repeat (15) @(negedge clk);

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort in the middle of a shamt=16 operation.
        issue(32'h12345678, 5'd16, 1'b0);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_dout", dout, 32'h0);
        repeat (10) @(negedge clk);

        // Abort while idle does not block a start in the same cycle.
        abort = 1'b1;
        issue(32'h00000007, 5'd1, 1'b1);
        abort = 1'b0;
        wait_done(b);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
